// File: rtl/tinycpu_pkg.sv
// Shared types and constants for the tinycpu memory-side blocks.
package tinycpu_pkg;

  // One-hot arbiter FSM encoding.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_ACK   = 4'b1000
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester picker: single request wins outright, ties go to the port
// that did not win last time, or to port 0 when fixed priority is selected.
module rr_pick2
  import tinycpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       fixed_prio,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    unique case (req)
      2'b01:   winner = PORT_CPU;
      2'b10:   winner = PORT_DBG;
      2'b11:   winner = fixed_prio ? PORT_CPU : ~last_gnt;
      default: winner = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/tinycpu_mem_arbiter.sv
// Shares the single synchronous memory between the CPU port (0) and the
// loader/debug port (1); one access in flight, every output registered.
module tinycpu_mem_arbiter
  import tinycpu_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       gnt_id,
  output logic       busy
);

  localparam int unsigned LAT_EFF =
    (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
    (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [1:0] LAT_LOAD = 2'(LAT_EFF - 1);

  arb_state_e state, state_nxt;
  logic [1:0] lat_cnt;
  logic       last_gnt;
  logic       pick_valid, pick_winner;
  mem_req_t   sel_req;

  logic mem_en_nxt, busy_nxt, ack0_nxt, ack1_nxt;
  logic grant, capture;

  rr_pick2 u_pick (
    .req        ({req1, req0}),
    .last_gnt   (last_gnt),
    .fixed_prio (FIXED_PRIO != 0),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    sel_req = pick_winner ? '{we: we1, addr: addr1, wdata: wdata1}
                          : '{we: we0, addr: addr0, wdata: wdata0};
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pick_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (lat_cnt == '0) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so their next values derive from state_nxt.
  always_comb begin
    mem_en_nxt = (state_nxt == ST_ISSUE);
    busy_nxt   = (state_nxt != ST_IDLE);
    ack0_nxt   = (state_nxt == ST_ACK) && (gnt_id == PORT_CPU);
    ack1_nxt   = (state_nxt == ST_ACK) && (gnt_id == PORT_DBG);
    grant      = (state == ST_IDLE) && pick_valid;
    capture    = (state == ST_WAIT) && (lat_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      gnt_id    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      lat_cnt   <= '0;
      last_gnt  <= PORT_DBG;
    end else begin
      mem_en <= mem_en_nxt;
      busy   <= busy_nxt;
      ack0   <= ack0_nxt;
      ack1   <= ack1_nxt;
      // Winner's request fields go straight into the memory-side registers.
      if (grant) begin
        gnt_id    <= pick_winner;
        last_gnt  <= pick_winner;
        mem_we    <= sel_req.we;
        mem_addr  <= sel_req.addr;
        mem_wdata <= sel_req.wdata;
      end
      if (state == ST_ISSUE)
        lat_cnt <= LAT_LOAD;
      else if ((state == ST_WAIT) && (lat_cnt != '0))
        lat_cnt <= lat_cnt - 2'd1;
      if (capture)
        rdata <= mem_rdata;
    end
  end

endmodule
